// File: rtl/dct_engine_sched_if.sv
// dct_engine_sched_if
//   Bundles the scheduler's bus toward the block buffer, transpose buffer,
//   1-D DCT engine and coefficient stream.
//   master : the scheduler (drives reads, engine start, writes, emits, errors)
//   slave  : the surrounding datapath / testbench (drives block_full,
//            eng_done, cstrm_ready)
interface dct_engine_sched_if;
  logic       block_full;
  logic       blk_release;
  logic       blk_rd_en;
  logic [2:0] row_sel;
  logic       t_rd_en;
  logic       t_rd_bank;
  logic [2:0] col_sel;
  logic       eng_start;
  logic       eng_src;
  logic       eng_done;
  logic       t_wr_en;
  logic       t_wr_bank;
  logic [2:0] t_wr_row;
  logic       cstrm_ready;
  logic       col_vec_valid;
  logic [2:0] col_vec_idx;
  logic       block_done;
  logic       err_overrun;
  logic       err_timeout;

  modport master (
    input  block_full, eng_done, cstrm_ready,
    output blk_release, blk_rd_en, row_sel, t_rd_en, t_rd_bank, col_sel,
           eng_start, eng_src, t_wr_en, t_wr_bank, t_wr_row,
           col_vec_valid, col_vec_idx, block_done, err_overrun, err_timeout
  );

  modport slave (
    output block_full, eng_done, cstrm_ready,
    input  blk_release, blk_rd_en, row_sel, t_rd_en, t_rd_bank, col_sel,
           eng_start, eng_src, t_wr_en, t_wr_bank, t_wr_row,
           col_vec_valid, col_vec_idx, block_done, err_overrun, err_timeout
  );
endinterface

// File: rtl/dct_engine_sched.sv
// dct_engine_sched
//   Time-shares one 1-D DCT engine between the row pass (block buffer ->
//   transpose bank) and the column pass (transpose bank -> coeff stream),
//   so the row pass of block N+1 overlaps the column pass of block N.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dct_engine_sched_if.master (block buffer reads/release,
//                transpose reads/writes, engine start/done, column emit,
//                sticky overrun/timeout errors)
// Every output is a register: an action decided in a cycle shows up on the
// bus in the following cycle. Pulses last one cycle; indices, banks and
// eng_src hold their last value.
module dct_engine_sched #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  dct_engine_sched_if.master  bus
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {E_IDLE, E_START, E_WAIT} eng_e;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_e;

  eng_e           st_q, st_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           side_q, side_d;   // job side: 0 row, 1 column
  logic           rr_q, rr_d;       // side granted last

  bank_e          bank_q [2];
  logic           wr_bank_q, rd_bank_q;
  logic           row_act_q, row_pend_q;
  logic [3:0]     r_q;              // next row to run (8 = pass written)
  logic [2:0]     c_q;              // next column to run

  logic           blk_release_q, blk_release_d;
  logic           blk_rd_en_q, blk_rd_en_d;
  logic [2:0]     row_sel_q, row_sel_d;
  logic           t_rd_en_q, t_rd_en_d;
  logic           t_rd_bank_q, t_rd_bank_d;
  logic [2:0]     col_sel_q, col_sel_d;
  logic           eng_start_q, eng_start_d;
  logic           eng_src_q, eng_src_d;
  logic           t_wr_en_q, t_wr_en_d;
  logic           t_wr_bank_q, t_wr_bank_d;
  logic [2:0]     t_wr_row_q, t_wr_row_d;
  logic           col_vec_valid_q, col_vec_valid_d;
  logic [2:0]     col_vec_idx_q, col_vec_idx_d;
  logic           block_done_q, block_done_d;
  logic           err_overrun_q, err_timeout_q;

  logic row_elig, col_elig, gnt_col, col_gnt, row_done, col_done, to_hit;
  logic wr_free, start_pass;

  // A row job exists while the fill bank is still being written; this stays
  // true after blk_release so a timed-out row 7 can be retried.
  assign row_elig = (bank_q[wr_bank_q] == B_FILLING) && !r_q[3];
  assign col_elig = ((bank_q[rd_bank_q] == B_FULL) || (bank_q[rd_bank_q] == B_DRAINING))
                    && bus.cstrm_ready;

  // Fill bank is usable now, or frees this cycle via a column-7 completion.
  assign wr_free    = (bank_q[wr_bank_q] == B_EMPTY) ||
                      (col_done && (c_q == 3'd7) && (rd_bank_q == wr_bank_q));
  assign start_pass = wr_free && (row_pend_q || (bus.block_full && !row_act_q));

  always_comb begin
    st_d            = st_q;
    tmr_d           = tmr_q;
    side_d          = side_q;
    rr_d            = rr_q;
    blk_release_d   = 1'b0;
    blk_rd_en_d     = 1'b0;
    row_sel_d       = row_sel_q;
    t_rd_en_d       = 1'b0;
    t_rd_bank_d     = t_rd_bank_q;
    col_sel_d       = col_sel_q;
    eng_start_d     = 1'b0;
    eng_src_d       = eng_src_q;
    t_wr_en_d       = 1'b0;
    t_wr_bank_d     = t_wr_bank_q;
    t_wr_row_d      = t_wr_row_q;
    col_vec_valid_d = 1'b0;
    col_vec_idx_d   = col_vec_idx_q;
    block_done_d    = 1'b0;
    col_gnt         = 1'b0;
    row_done        = 1'b0;
    col_done        = 1'b0;
    to_hit          = 1'b0;
    gnt_col         = (row_elig && col_elig) ? !rr_q : col_elig;
    case (st_q)
      E_IDLE: begin
        if (row_elig || col_elig) begin
          st_d   = E_START;
          side_d = gnt_col;
          rr_d   = gnt_col;
          if (gnt_col) begin
            col_gnt     = 1'b1;
            t_rd_en_d   = 1'b1;
            t_rd_bank_d = rd_bank_q;
            col_sel_d   = c_q;
          end else begin
            blk_rd_en_d   = 1'b1;
            row_sel_d     = r_q[2:0];
            // row_act_q gate keeps a retried row 7 from releasing twice
            blk_release_d = (r_q == 4'd7) && row_act_q;
          end
        end
      end
      E_START: begin
        eng_start_d = 1'b1;
        eng_src_d   = side_q;
        tmr_d       = '0;
        st_d        = E_WAIT;
      end
      E_WAIT: begin
        if (bus.eng_done) begin
          st_d = E_IDLE;
          if (!side_q) begin
            row_done    = 1'b1;
            t_wr_en_d   = 1'b1;
            t_wr_bank_d = wr_bank_q;
            t_wr_row_d  = r_q[2:0];
          end else begin
            col_done        = 1'b1;
            col_vec_valid_d = 1'b1;
            col_vec_idx_d   = c_q;
            block_done_d    = (c_q == 3'd7);
          end
        end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
          // abandon the job; indices are untouched so it is re-arbitrated
          to_hit = 1'b1;
          st_d   = E_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: st_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q            <= E_IDLE;
      tmr_q           <= '0;
      side_q          <= 1'b0;
      rr_q            <= 1'b0;
      blk_release_q   <= 1'b0;
      blk_rd_en_q     <= 1'b0;
      row_sel_q       <= '0;
      t_rd_en_q       <= 1'b0;
      t_rd_bank_q     <= 1'b0;
      col_sel_q       <= '0;
      eng_start_q     <= 1'b0;
      eng_src_q       <= 1'b0;
      t_wr_en_q       <= 1'b0;
      t_wr_bank_q     <= 1'b0;
      t_wr_row_q      <= '0;
      col_vec_valid_q <= 1'b0;
      col_vec_idx_q   <= '0;
      block_done_q    <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      st_q            <= st_d;
      tmr_q           <= tmr_d;
      side_q          <= side_d;
      rr_q            <= rr_d;
      blk_release_q   <= blk_release_d;
      blk_rd_en_q     <= blk_rd_en_d;
      row_sel_q       <= row_sel_d;
      t_rd_en_q       <= t_rd_en_d;
      t_rd_bank_q     <= t_rd_bank_d;
      col_sel_q       <= col_sel_d;
      eng_start_q     <= eng_start_d;
      eng_src_q       <= eng_src_d;
      t_wr_en_q       <= t_wr_en_d;
      t_wr_bank_q     <= t_wr_bank_d;
      t_wr_row_q      <= t_wr_row_d;
      col_vec_valid_q <= col_vec_valid_d;
      col_vec_idx_q   <= col_vec_idx_d;
      block_done_q    <= block_done_d;
      err_timeout_q   <= err_timeout_q | to_hit;
    end
  end

  // Bank bookkeeping and row-side admission. Statement order matters:
  // a bank emptied by column 7 may be re-claimed as FILLING in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      row_act_q     <= 1'b0;
      row_pend_q    <= 1'b0;
      r_q           <= '0;
      c_q           <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      // the pass counts as active through the cycle blk_release is visible
      if (blk_release_q) row_act_q <= 1'b0;
      if (bus.block_full) begin
        if (row_act_q || row_pend_q) err_overrun_q <= 1'b1;
        else if (!wr_free)           row_pend_q    <= 1'b1;
      end
      if (col_gnt && (c_q == 3'd0)) bank_q[rd_bank_q] <= B_DRAINING;
      if (row_done) begin
        r_q <= r_q + 4'd1;
        if (r_q == 4'd7) begin
          bank_q[wr_bank_q] <= B_FULL;
          wr_bank_q         <= ~wr_bank_q;
        end
      end
      if (col_done) begin
        c_q <= c_q + 3'd1;
        if (c_q == 3'd7) begin
          bank_q[rd_bank_q] <= B_EMPTY;
          rd_bank_q         <= ~rd_bank_q;
        end
      end
      if (start_pass) begin
        row_act_q         <= 1'b1;
        row_pend_q        <= 1'b0;
        r_q               <= '0;
        bank_q[wr_bank_q] <= B_FILLING;
      end
    end
  end

  assign bus.blk_release   = blk_release_q;
  assign bus.blk_rd_en     = blk_rd_en_q;
  assign bus.row_sel       = row_sel_q;
  assign bus.t_rd_en       = t_rd_en_q;
  assign bus.t_rd_bank     = t_rd_bank_q;
  assign bus.col_sel       = col_sel_q;
  assign bus.eng_start     = eng_start_q;
  assign bus.eng_src       = eng_src_q;
  assign bus.t_wr_en       = t_wr_en_q;
  assign bus.t_wr_bank     = t_wr_bank_q;
  assign bus.t_wr_row      = t_wr_row_q;
  assign bus.col_vec_valid = col_vec_valid_q;
  assign bus.col_vec_idx   = col_vec_idx_q;
  assign bus.block_done    = block_done_q;
  assign bus.err_overrun   = err_overrun_q;
  assign bus.err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_dct_engine_sched.sv
// tb_dct_engine_sched
//   Directed scenarios with randomized engine latency, gaps and stream
//   back-pressure. A monitor logs bus events; the expected logs come from a
//   block-level model (block k fills bank k%2 rows 0..7, then drains it
//   columns 0..7 with one block_done on column 7).
module tb_dct_engine_sched;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dct_engine_sched_if bus();
  dct_engine_sched #(.DONE_TIMEOUT(TO)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 3;
  bit suppress = 1'b0;
  bit rand_rdy = 1'b0;
  bit rdy_lvl = 1'b1;

  logic [3:0] wr_q[$], trd_q[$], rrd_q[$], cv_q[$], bd_q[$];
  logic [3:0] ewr[$], etrd[$], erow[$], ecv[$], ebd[$];
  bit gnt_q[$];
  int rel_cnt = 0, bd_cnt = 0, last_start = 0, to_delta = 0;
  bit to_seen = 1'b0;
  logic prev_rd_row = 1'b0, prev_rd_col = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {bus.blk_release, bus.blk_rd_en, bus.row_sel, bus.t_rd_en, bus.t_rd_bank,
            bus.col_sel, bus.eng_start, bus.eng_src, bus.t_wr_en, bus.t_wr_bank,
            bus.t_wr_row, bus.col_vec_valid, bus.col_vec_idx, bus.block_done,
            bus.err_overrun, bus.err_timeout};
  endfunction

  // event monitor
  always @(negedge clk) begin
    cyc++;
    if (bus.blk_rd_en) begin rrd_q.push_back({1'b0, bus.row_sel}); gnt_q.push_back(1'b0); end
    if (bus.t_rd_en) begin trd_q.push_back({bus.t_rd_bank, bus.col_sel}); gnt_q.push_back(1'b1); end
    if (bus.t_wr_en) wr_q.push_back({bus.t_wr_bank, bus.t_wr_row});
    if (bus.col_vec_valid) cv_q.push_back({1'b0, bus.col_vec_idx});
    if (bus.block_done) begin bd_cnt++; bd_q.push_back({bus.col_vec_valid, bus.col_vec_idx}); end
    if (bus.blk_release) rel_cnt++;
    if (bus.eng_start) begin
      last_start = cyc;
      check("start_follows_read", {30'd0, prev_rd_row | prev_rd_col, bus.eng_src},
            {30'd0, 1'b1, prev_rd_col});
    end
    if (bus.err_timeout && !to_seen) begin to_seen = 1'b1; to_delta = cyc - last_start; end
    prev_rd_row = bus.blk_rd_en;
    prev_rd_col = bus.t_rd_en;
  end

  // engine model (fixed latency after eng_start) and stream ready driver
  initial begin
    int cnt;
    cnt = 0;
    bus.eng_done = 1'b0;
    bus.cstrm_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !suppress) bus.eng_done = 1'b1;
      end
      if (bus.eng_start) cnt = lat;
      bus.cstrm_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_lvl;
    end
  end

  task automatic clear_logs();
    wr_q.delete(); trd_q.delete(); rrd_q.delete(); cv_q.delete(); bd_q.delete();
    gnt_q.delete();
    rel_cnt = 0; bd_cnt = 0; to_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.block_full = 1'b0;
    suppress = 1'b0; rand_rdy = 1'b0; rdy_lvl = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic pulse_now();
    #1 bus.block_full = 1'b1;
    @(posedge clk);
    #1 bus.block_full = 1'b0;
  endtask

  task automatic pulse();
    @(posedge clk);
    pulse_now();
  endtask

  function automatic int counter(input int which);
    case (which)
      0: return bd_cnt;
      1: return wr_q.size();
      2: return rel_cnt;
      3: return rrd_q.size();
      4: return trd_q.size();
      default: return int'(to_seen);
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int which, input int n, input int budget);
    int k;
    k = 0;
    while (counter(which) < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_reached"}, 32'(counter(which) >= n), 32'd1);
  endtask

  task automatic model(input int n);
    ewr.delete(); etrd.delete(); erow.delete(); ecv.delete(); ebd.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        ewr.push_back(4'((k % 2) * 8 + i));
        etrd.push_back(4'((k % 2) * 8 + i));
        erow.push_back(4'(i));
        ecv.push_back(4'(i));
      end
      ebd.push_back(4'hF);
    end
  endtask

  task automatic cmp_q(input string tag, input logic [3:0] obs[$], input logic [3:0] exp[$]);
    check({tag, "_len"}, 32'(obs.size()), 32'(exp.size()));
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(obs[i]), 32'(exp[i]));
  endtask

  task automatic cmp_all(input string tag, input bit rows);
    cmp_q({tag, "_twr"}, wr_q, ewr);
    cmp_q({tag, "_trd"}, trd_q, etrd);
    cmp_q({tag, "_colvec"}, cv_q, ecv);
    cmp_q({tag, "_bdone"}, bd_q, ebd);
    if (rows) cmp_q({tag, "_rowsel"}, rrd_q, erow);
  endtask

  initial begin
    bus.block_full = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    clear_logs();

    // 1: single block
    lat = $urandom_range(1, 5);
    pulse();
    wait_cnt("t1_done", 0, 1, 600);
    repeat (10) @(posedge clk);
    model(1);
    cmp_all("t1", 1'b1);
    check("t1_release", 32'(rel_cnt), 32'd1);
    check("t1_gnt_len", 32'(gnt_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < gnt_q.size(); i++)
      check($sformatf("t1_gnt[%0d]", i), 32'(gnt_q[i]), 32'(i >= 8));

    // 2: two blocks, second right after release
    do_reset();
    lat = $urandom_range(1, 5);
    pulse();
    wait_cnt("t2_rel", 2, 1, 400);
    pulse_now();
    wait_cnt("t2_done", 0, 2, 1500);
    repeat (10) @(posedge clk);
    model(2);
    cmp_all("t2", 1'b1);
    check("t2_overrun", 32'(bus.err_overrun), 32'd0);
    check("t2_gnt_len", 32'(gnt_q.size()), 32'd32);
    if (gnt_q.size() == 32) begin
      for (int i = 8; i < 23; i++)
        check($sformatf("t2_alt[%0d]", i), 32'(gnt_q[i] != gnt_q[i+1]), 32'd1);
      check("t2_first_col", 32'(gnt_q[8]), 32'd1);
    end

    // 3: stream stalled, banks fill, third pends, fourth overruns
    do_reset();
    rdy_lvl = 1'b0;
    lat = $urandom_range(1, 5);
    pulse();
    wait_cnt("t3_wr8", 1, 8, 400);
    pulse();
    wait_cnt("t3_wr16", 1, 16, 400);
    pulse();
    repeat (20) @(posedge clk);
    #1 check("t3_no_overrun", 32'(bus.err_overrun), 32'd0);
    check("t3_no_colreads", 32'(trd_q.size()), 32'd0);
    check("t3_wr_held", 32'(wr_q.size()), 32'd16);
    pulse();
    @(posedge clk);
    #1 check("t3_overrun", 32'(bus.err_overrun), 32'd1);
    rdy_lvl = 1'b1;
    wait_cnt("t3_done", 0, 3, 2500);
    repeat (20) @(posedge clk);
    model(3);
    cmp_all("t3", 1'b1);

    // 4: engine silent -> timeout after DONE_TIMEOUT wait cycles, retry
    do_reset();
    lat = 2;
    suppress = 1'b1;
    pulse();
    wait_cnt("t4_timeout", 5, 1, 300);
    suppress = 1'b0;
    check("t4_to_delay", 32'(to_delta), 32'(TO));
    wait_cnt("t4_done", 0, 1, 800);
    repeat (5) @(posedge clk);
    #1 check("t4_err_sticky", 32'(bus.err_timeout), 32'd1);
    check("t4_reads", 32'(rrd_q.size()), 32'd9);
    check("t4_row0_first", 32'(rrd_q[0]), 32'd0);
    check("t4_row0_retry", 32'(rrd_q[1]), 32'd0);
    model(1);
    cmp_all("t4", 1'b0);

    // 5: reset during column 4, stale eng_done afterwards
    do_reset();
    lat = 6;
    pulse();
    wait_cnt("t5_col4", 4, 5, 800);
    check("t5_col4_idx", 32'(trd_q[4]), 32'd4);
    #1 rst_n = 1'b0;
    #1 check("t5_reset_outs", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (12) @(posedge clk);
    #1 check("t5_stale_ignored", 32'(outs()), 32'd0);
    check("t5_no_writes", 32'(wr_q.size() + cv_q.size()), 32'd0);
    pulse();
    wait_cnt("t5_done", 0, 1, 600);
    repeat (10) @(posedge clk);
    model(1);
    cmp_all("t5", 1'b1);

    // 6: block_full during row 3
    do_reset();
    lat = $urandom_range(1, 5);
    pulse();
    wait_cnt("t6_row3", 3, 4, 400);
    pulse_now();
    #1 check("t6_overrun", 32'(bus.err_overrun), 32'd1);
    wait_cnt("t6_done", 0, 1, 600);
    repeat (40) @(posedge clk);
    check("t6_one_block", 32'(bd_cnt), 32'd1);
    model(1);
    cmp_all("t6", 1'b1);

    // 7: four blocks, random gaps and back-pressure
    do_reset();
    rand_rdy = 1'b1;
    lat = $urandom_range(1, 5);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_cnt($sformatf("t7_rel%0d", k), 2, k, 2000);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      pulse();
    end
    wait_cnt("t7_done", 0, 4, 8000);
    repeat (10) @(posedge clk);
    rand_rdy = 1'b0;
    model(4);
    cmp_all("t7", 1'b1);
    check("t7_errs", 32'({bus.err_overrun, bus.err_timeout}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
